// File: rtl/ysyx_23060136_mem_rd_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory read arbiter.
// Holds the FSM state encoding, the owner codes and the AXI response helper.
package ysyx_23060136_mem_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } arb_owner_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_23060136_arb_starve_ctr.sv
// Counts consecutive LSU wins while the IFU is waiting; raises force_ifu
// once STARVE_MAX such wins have happened so the IFU gets the next grant.
module ysyx_23060136_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic lsu_grant,
    input  logic ifu_grant,
    input  logic ifu_pending,
    output logic force_ifu
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: saturating increment on a contested LSU win, clear on any other grant.
    always_comb begin
        cnt_d = cnt_q;
        if (lsu_grant && ifu_pending) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (lsu_grant || ifu_grant) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_ifu = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ysyx_23060136_mem_rd_arbiter.sv
// Shares one AXI-lite AR/R read channel between IFU fetch and LSU load with a
// single outstanding read; LSU has priority, bounded by an anti-starvation counter.
module ysyx_23060136_mem_rd_arbiter
    import ysyx_23060136_mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ARBITER_IFU_pc,
    input  logic              ARBITER_IFU_pc_valid,
    output logic              ARBITER_IFU_pc_ready,
    output logic [DATA_W-1:0] ARBITER_IFU_inst,
    output logic              ARBITER_IFU_inst_valid,
    input  logic              ARBITER_IFU_inst_ready,
    input  logic [ADDR_W-1:0] ARBITER_LSU_raddr,
    input  logic              ARBITER_LSU_raddr_valid,
    output logic              ARBITER_LSU_raddr_ready,
    output logic [DATA_W-1:0] ARBITER_LSU_rdata,
    output logic [1:0]        ARBITER_LSU_rresp,
    output logic              ARBITER_LSU_rdata_valid,
    input  logic              ARBITER_LSU_rdata_ready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              ARBITER_error_signal
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    arb_owner_e        owner_q;
    arb_owner_e        owner_d;
    logic [ADDR_W-1:0] araddr_q;
    logic [ADDR_W-1:0] araddr_d;

    logic ifu_grant_s;
    logic lsu_grant_s;
    logic force_ifu_s;
    logic rready_s;
    logic in_data_s;

    ysyx_23060136_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .lsu_grant   (lsu_grant_s),
        .ifu_grant   (ifu_grant_s),
        .ifu_pending (ARBITER_IFU_pc_valid),
        .force_ifu   (force_ifu_s)
    );

    assign in_data_s = (state_q == ST_DATA);
    assign rready_s  = in_data_s && ((owner_q == OWNER_LSU) ? ARBITER_LSU_rdata_ready
                                                            : ARBITER_IFU_inst_ready);

    // Next-state, grant decision and address/owner capture.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        araddr_d    = araddr_q;
        ifu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Grants are suppressed while reset is held so no requester sees a phantom handshake.
                if (!rst && ARBITER_LSU_raddr_valid && !(ARBITER_IFU_pc_valid && force_ifu_s)) begin
                    lsu_grant_s = 1'b1;
                    owner_d     = OWNER_LSU;
                    araddr_d    = ARBITER_LSU_raddr;
                    state_d     = ST_ADDR;
                end else if (!rst && ARBITER_IFU_pc_valid) begin
                    ifu_grant_s = 1'b1;
                    owner_d     = OWNER_IFU;
                    araddr_d    = ARBITER_IFU_pc;
                    state_d     = ST_ADDR;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rvalid && rready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side and upstream output steering; read data passes straight through.
    always_comb begin
        ARBITER_IFU_pc_ready    = ifu_grant_s;
        ARBITER_LSU_raddr_ready = lsu_grant_s;
        arvalid                 = (state_q == ST_ADDR);
        araddr                  = araddr_q;
        rready                  = rready_s;
        ARBITER_IFU_inst_valid  = in_data_s && (owner_q == OWNER_IFU) && rvalid;
        ARBITER_LSU_rdata_valid = in_data_s && (owner_q == OWNER_LSU) && rvalid;
        ARBITER_IFU_inst        = rdata;
        ARBITER_LSU_rdata       = rdata;
        ARBITER_LSU_rresp       = rresp;
        ARBITER_error_signal    = in_data_s && (owner_q == OWNER_IFU) && rvalid
                                  && rready_s && resp_is_error(rresp);
    end

    // State, owner and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_IFU;
            araddr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            araddr_q <= araddr_d;
        end
    end

endmodule
